// File: rtl/seq_shared_reg_rr_arbiter.sv
// Shared NBITS register written by one of NREQ requesters per cycle.
// A round-robin pointer picks the writer; owner records who wrote q last.
module seq_shared_reg_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] wdata,
  output logic [NREQ-1:0]       grant,
  output logic [NBITS-1:0]      q,
  output logic                  q_valid,
  output logic [OW-1:0]         owner
);

  logic [OW-1:0]    ptr;
  logic [OW-1:0]    win_idx;
  logic [OW-1:0]    idx;
  logic             win;
  logic [NREQ-1:0]  grant_raw;
  logic [NBITS-1:0] wdata_arr [NREQ];
  int               pos;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign wdata_arr[i] = wdata[i*NBITS +: NBITS];
  end

  // Search begins at ptr and wraps, so the requester just served drops to lowest priority.
  always_comb begin
    grant_raw = '0;
    win       = 1'b0;
    win_idx   = '0;
    idx       = '0;
    pos       = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = OW'(pos);
      if (!win && req[idx]) begin
        win            = 1'b1;
        grant_raw[idx] = 1'b1;
        win_idx        = idx;
      end
    end
  end

  assign grant = reset ? '0 : grant_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q       <= '0;
      q_valid <= 1'b0;
      owner   <= '0;
      ptr     <= '0;
    end else if (win) begin
      q       <= wdata_arr[win_idx];
      q_valid <= 1'b1;
      owner   <= win_idx;
      ptr     <= (win_idx == OW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_shared_reg_rr_arbiter.sv
// Scoreboard bench for seq_shared_reg_rr_arbiter (NREQ=4, NBITS=8): directed
// vectors with hand-computed expectations, then a randomized run against a golden model.
module tb_seq_shared_reg_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  grant;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  owner;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [3:0] g;
    logic [7:0] q;
    logic       v;
    logic [1:0] o;
    logic       onehot_chk;
  } exp_t;

  exp_t sb[$];

  // golden model state for the randomized section
  logic [7:0] m_q;
  logic       m_v;
  logic [1:0] m_o;
  logic [1:0] m_ptr;

  seq_shared_reg_rr_arbiter #(.NREQ(4), .NBITS(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wdata   (wdata),
    .grant   (grant),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  // Monitor: samples one unit before each rising edge and pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #9;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".grant"},   32'(grant),   32'(e.g));
        chk({e.name, ".q"},       32'(q),       32'(e.q));
        chk({e.name, ".q_valid"}, 32'(q_valid), 32'(e.v));
        chk({e.name, ".owner"},   32'(owner),   32'(e.o));
        if (e.onehot_chk)
          chk({e.name, ".onehot0"}, 32'($onehot0(grant)), 32'd1);
      end
    end
  end

  // Applies inputs 1 unit after the edge; mid=1 raises reset halfway through the cycle.
  task automatic step(input string name, input logic rst, input logic mid,
                      input logic [3:0] r, input logic [31:0] wd,
                      input logic [3:0] eg, input logic [7:0] eq,
                      input logic ev, input logic [1:0] eo, input logic oh);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    req   = r;
    wdata = wd;
    e.name = name; e.g = eg; e.q = eq; e.v = ev; e.o = eo; e.onehot_chk = oh;
    sb.push_back(e);
    if (mid) begin
      #4;
      reset = 1'b1;
    end
  endtask

  function automatic logic [3:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (int'(p) + k) % 4;
      if (r[i]) return 4'b0001 << i;
    end
    return 4'b0000;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  rr;
    logic [31:0] rwd;
    logic        rrst;
    logic [3:0]  eg;
    int          wi;

    reset = 1'b1;
    req   = 4'b0000;
    wdata = 32'h0;

    step("rst_hold",  1, 0, 4'b0000, 32'h0,        4'b0000, 8'h00, 0, 2'd0, 0);
    // single requester 2, then idle holds
    step("single",    0, 0, 4'b0100, 32'h003C0000, 4'b0100, 8'h00, 0, 2'd0, 0);
    step("idle1",     0, 0, 4'b0000, 32'hFFFFFFFF, 4'b0000, 8'h3C, 1, 2'd2, 0);
    step("idle2",     0, 0, 4'b0000, 32'h0,        4'b0000, 8'h3C, 1, 2'd2, 0);
    // ptr=3, req=0011 wraps to 0, then 1
    step("wrap_a",    0, 0, 4'b0011, 32'h44332211, 4'b0001, 8'h3C, 1, 2'd2, 0);
    step("wrap_b",    0, 0, 4'b0011, 32'h44332211, 4'b0010, 8'h11, 1, 2'd0, 0);
    // load 0x5A, then reset in the middle of a cycle with a pending req
    step("load5a",    0, 0, 4'b1000, 32'h5A000000, 4'b1000, 8'h22, 1, 2'd1, 0);
    step("midrst",    0, 1, 4'b0001, 32'h000000EE, 4'b0000, 8'h00, 0, 2'd0, 0);
    step("post_rst",  0, 0, 4'b0000, 32'h0,        4'b0000, 8'h00, 0, 2'd0, 0);
    // all requesting: rotate 0,1,2,3 and wrap to 0
    step("all_c1",    0, 0, 4'b1111, 32'h13121110, 4'b0001, 8'h00, 0, 2'd0, 0);
    step("all_c2",    0, 0, 4'b1111, 32'h13121110, 4'b0010, 8'h10, 1, 2'd0, 0);
    step("all_c3",    0, 0, 4'b1111, 32'h13121110, 4'b0100, 8'h11, 1, 2'd1, 0);
    step("all_c4",    0, 0, 4'b1111, 32'h13121110, 4'b1000, 8'h12, 1, 2'd2, 0);
    step("all_c5",    0, 0, 4'b1111, 32'h13121110, 4'b0001, 8'h13, 1, 2'd3, 0);
    step("all_idle",  0, 0, 4'b0000, 32'h0,        4'b0000, 8'h10, 1, 2'd0, 0);
    // reset coinciding with an edge while all request: no write, ptr back to 0
    step("rst_req",   1, 0, 4'b1111, 32'hDDCCBBAA, 4'b0000, 8'h00, 0, 2'd0, 0);
    step("rel_first", 0, 0, 4'b1111, 32'hDDCCBBAA, 4'b0001, 8'h00, 0, 2'd0, 0);
    // a lone requester wins back-to-back
    step("lone_a",    0, 0, 4'b0100, 32'hDDCCBBAA, 4'b0100, 8'hAA, 1, 2'd0, 0);
    step("lone_b",    0, 0, 4'b0100, 32'hDDCCBBAA, 4'b0100, 8'hCC, 1, 2'd2, 0);
    step("lone_idle", 0, 0, 4'b0000, 32'h0,        4'b0000, 8'hCC, 1, 2'd2, 0);

    // model state after the directed section
    m_q = 8'hCC; m_v = 1'b1; m_o = 2'd2; m_ptr = 2'd3;

    for (int n = 0; n < 200; n++) begin
      rr   = 4'($urandom_range(0, 15));
      rwd  = $urandom;
      rrst = ($urandom_range(0, 15) == 0);
      if (rrst) begin
        m_q = 8'h00; m_v = 1'b0; m_o = 2'd0; m_ptr = 2'd0;
        eg  = 4'b0000;
      end else begin
        eg = rr_pick(m_ptr, rr);
      end
      step("rand", rrst, 0, rr, rwd, eg, m_q, m_v, m_o, 1);
      if (!rrst && eg != 4'b0000) begin
        wi    = 0;
        for (int i = 0; i < 4; i++) if (eg[i]) wi = i;
        m_q   = rwd[wi*8 +: 8];
        m_v   = 1'b1;
        m_o   = 2'(wi);
        m_ptr = 2'((wi + 1) % 4);
      end
    end

    @(posedge clk);
    #2;
    req = 4'b0000;
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
